ascon_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO that serves the Ascon core's three data channels. One instance feeds associated data, one feeds plaintext, and one absorbs ciphertext. It answers the core's pop/empty/flush requests on the read side and push/full/flush requests on the write side. The host bus writes AD/PT words in and reads CT words out. Depth and width are parameterised so each instance matches the core's block-count width.

---
 rtl/ascon_fifo_pkg.sv | 9 +
 rtl/ascon_fifo_if.sv | 31 +++
 rtl/ascon_fifo_mem.sv | 26 ++
 rtl/ascon_fifo.sv | 114 +++++++++++
 tb/tb_ascon_fifo.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ascon_fifo_pkg.sv
// Shared Ascon constants and the rate-block word type.
package ascon_pack;

  localparam int unsigned ASCON_BLK_W  = 64;
  localparam int unsigned ASCON_ADDR_W = 7;

  typedef logic [ASCON_BLK_W-1:0] ascon_blk_t;

endpackage

// File: rtl/ascon_fifo_if.sv
// Handshake bundle between an Ascon channel FIFO and its producer/consumer.
// The slave modport is the FIFO side; master is the host/core side.
interface ascon_fifo_if
  import ascon_pack::*;
#(
  parameter int unsigned DataWidth = ASCON_BLK_W,
  parameter int unsigned AddrWidth = ASCON_ADDR_W
);

  logic                 flush_i;
  logic                 push_i;
  logic [DataWidth-1:0] data_i;
  logic                 full_o;
  logic                 pop_i;
  logic [DataWidth-1:0] data_o;
  logic                 empty_o;
  logic [AddrWidth:0]   level_o;
  logic                 overflow_o;
  logic                 underflow_o;

  modport master (
    output flush_i, push_i, data_i, pop_i,
    input  full_o, data_o, empty_o, level_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, data_i, pop_i,
    output full_o, data_o, empty_o, level_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/ascon_fifo_mem.sv
// Storage array for ascon_fifo: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 clk_i,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [2**AddrWidth];

  // Write port: store one word per accepted push.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ascon_fifo.sv
// First-word-fall-through FIFO for the Ascon AD/PT/CT channels.
// Optional sticky overflow/underflow flags are built when the macro
// ASCON_FIFO_ERR_EN is defined; otherwise both outputs are tied to 0.
module ascon_fifo
  import ascon_pack::*;
#(
  parameter int unsigned DataWidth = ASCON_BLK_W,
  parameter int unsigned AddrWidth = ASCON_ADDR_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  ascon_fifo_if.slave  bus
);

  localparam logic [AddrWidth:0] DepthLvl = {1'b1, {AddrWidth{1'b0}}};

  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic [AddrWidth:0]   level;
  logic [AddrWidth:0]   level_nxt;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 pop_ok;
  logic [DataWidth-1:0] head;

  // When full, a push is only taken alongside a pop, which then must succeed.
  assign push_ok = bus.push_i & (~full | bus.pop_i);
  assign pop_ok  = bus.pop_i & ~empty;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_nxt = level - 1'b1;
    end
  end

  // Pointers, level and registered full/empty; flush overrides push/pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      full  <= (level_nxt == DepthLvl);
      empty <= (level_nxt == '0);
    end
  end

  fifo_mem #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) u_mem (
    .clk_i (clk_i),
    .we    (push_ok & ~bus.flush_i),
    .waddr (wr_ptr),
    .wdata (bus.data_i),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.data_o  = empty ? '0 : head;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.level_o = level;

`ifdef ASCON_FIFO_ERR_EN
  logic overflow;
  logic underflow;

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.flush_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.push_i && !push_ok) begin
        overflow <= 1'b1;
      end
      if (bus.pop_i && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;
`else
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_fifo.sv
// Randomised bench for ascon_fifo against a queue-based reference model.
// Flag expectations follow ASCON_FIFO_ERR_EN.
module tb_ascon_fifo;

`ifdef ASCON_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ascon_fifo_if #(.DataWidth(64), .AddrWidth(7)) bus ();

  ascon_fifo #(.DataWidth(64), .AddrWidth(7)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Reference model: a queue of stored words plus sticky flags.
  logic [63:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always @(negedge rst_n) begin
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.flush_i) begin
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        bit was_full, was_empty, pu_acc, po_acc;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        pu_acc    = bus.push_i && (!was_full || bus.pop_i);
        po_acc    = bus.pop_i && !was_empty;
        if (bus.push_i && !pu_acc) m_ovf = 1'b1;
        if (bus.pop_i && !po_acc)  m_unf = 1'b1;
        if (po_acc) void'(q.pop_front());
        if (pu_acc) q.push_back(bus.data_i);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [63:0] exp_d;
    exp_d = (q.size() != 0) ? q[0] : 64'h0;
    chk("level", 64'(bus.level_o), 64'(q.size()));
    chk("empty", 64'(bus.empty_o), 64'(q.size() == 0));
    chk("full", 64'(bus.full_o), 64'(q.size() == DEPTH));
    chk("data", bus.data_o, exp_d);
    chk("ovf", 64'(bus.overflow_o), 64'(ERR & m_ovf));
    chk("unf", 64'(bus.underflow_o), 64'(ERR & m_unf));
  end

  // Drive one cycle of inputs from a falling edge to the next falling edge.
  task automatic step(input logic f, input logic pu, input logic [63:0] d, input logic po);
    bus.flush_i = f;
    bus.push_i  = pu;
    bus.data_i  = d;
    bus.pop_i   = po;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_empty"}, 64'(bus.empty_o), 64'd1);
    chk({tag, "_full"}, 64'(bus.full_o), 64'd0);
    chk({tag, "_level"}, 64'(bus.level_o), 64'd0);
    chk({tag, "_data"}, bus.data_o, 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow_o), 64'd0);
    chk({tag, "_unf"}, 64'(bus.underflow_o), 64'd0);
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.push_i  = 1'b0;
    bus.data_i  = '0;
    bus.pop_i   = 1'b0;
    #1 rst_n = 1'b0;
    #1 reset_literals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill 1..128
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 64'(i), 1'b0);
      chk("fill_level", 64'(bus.level_o), 64'(i));
      chk("fill_empty", 64'(bus.empty_o), 64'd0);
      chk("fill_full", 64'(bus.full_o), 64'(i == DEPTH));
    end

    // Fall-through drain: head is valid in the cycle it is popped
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_data", bus.data_o, 64'(i));
      step(1'b0, 1'b0, 64'h0, 1'b1);
    end
    chk("drain_empty", 64'(bus.empty_o), 64'd1);
    chk("drain_zero", bus.data_o, 64'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 64'(i), 1'b0);
    step(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b1);
    chk("pp_level", 64'(bus.level_o), 64'd128);
    chk("pp_head", bus.data_o, 64'd2);
    chk("pp_ovf", 64'(bus.overflow_o), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("pp_last", bus.data_o, 64'hDEAD_BEEF_0000_0000);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("pp_empty", 64'(bus.empty_o), 64'd1);

    // Error flags
    for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 64'h100 + 64'(i), 1'b0);
    step(1'b0, 1'b1, 64'hFFFF, 1'b0);
    chk("ovf_set", 64'(bus.overflow_o), 64'(ERR));
    step(1'b0, 1'b0, 64'h0, 1'b0);
    chk("ovf_sticky", 64'(bus.overflow_o), 64'(ERR));
    chk("ovf_level", 64'(bus.level_o), 64'd128);
    chk("ovf_head", bus.data_o, 64'h101);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    chk("unf_set", 64'(bus.underflow_o), 64'(ERR));
    step(1'b0, 1'b1, 64'h77, 1'b1);
    chk("emp_pp_level", 64'(bus.level_o), 64'd1);
    chk("emp_pp_data", bus.data_o, 64'h77);
    step(1'b1, 1'b0, 64'h0, 1'b0);
    chk("flush_ovf", 64'(bus.overflow_o), 64'd0);
    chk("flush_unf", 64'(bus.underflow_o), 64'd0);

    // Flush precedence
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'h500 + 64'(i), 1'b0);
    step(1'b1, 1'b1, 64'h9999, 1'b1);
    chk("fp_level", 64'(bus.level_o), 64'd0);
    chk("fp_empty", 64'(bus.empty_o), 64'd1);
    chk("fp_ovf", 64'(bus.overflow_o), 64'd0);
    chk("fp_unf", 64'(bus.underflow_o), 64'd0);
    step(1'b0, 1'b1, 64'h1234, 1'b0);
    chk("fp_data", bus.data_o, 64'h1234);
    step(1'b1, 1'b0, 64'h0, 1'b0);

    // Stream 300 words around level ~3 across pointer wrap
    begin
      int sent = 0;
      while (sent < 300 || q.size() != 0) begin
        logic pu, po;
        pu = (sent < 300) && ($urandom_range(0, 3) != 0);
        po = (q.size() >= 3) || (sent >= 300);
        step(1'b0, pu, {$urandom, $urandom}, po);
        if (pu) sent++;
      end
    end

    // Random mix biased toward full and empty corners
    for (int i = 0; i < 3000; i++) begin
      int phase = (i / 400) % 3;
      int pp = (phase == 0) ? 90 : (phase == 1) ? 15 : 55;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < pp,
           {$urandom, $urandom},
           $urandom_range(0, 99) < (100 - pp));
    end

    // Asynchronous reset between edges, mid-stream
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 64'hA0 + 64'(i), 1'b0);
    bus.push_i = 1'b1;
    bus.pop_i  = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_literals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++)
      step(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 2) == 0);
    step(1'b0, 1'b0, 64'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
